// File: rtl/calib_stats.sv
// Window mean / standard-deviation engine feeding the normalizer stage.
// Optional: define CALIB_STD_CLAMP_EN to clamp o_std to a minimum of 1.
module calib_stats #(
   parameter int LOG2_N = 6
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_start,
   input  logic        i_sample_valid,
   input  logic [15:0] i_sample,
   output logic [15:0] o_mean,
   output logic [15:0] o_std,
   output logic        o_valid,
   output logic        o_busy,
   output logic        o_done
);

   localparam int SW = 16 + LOG2_N;
   localparam int QW = 32 + LOG2_N;

`ifdef CALIB_STD_CLAMP_EN
   localparam logic [15:0] STD_RST = 16'd1;
`else
   localparam logic [15:0] STD_RST = 16'd0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_VAR,
      S_SQRT,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [SW-1:0]       r_sum;
   logic [QW-1:0]       r_sumsq;
   logic [LOG2_N-1:0]   r_cnt;
   logic [4:0]          r_it;
   logic [15:0]         r_mean;
   logic [31:0]         r_rad;
   logic [19:0]         r_rem;
   logic [15:0]         r_root;

   logic [31:0]         w_sq;
   logic [15:0]         w_mean;
   logic [31:0]         w_ex2;
   logic [31:0]         w_mm;
   logic [31:0]         w_var;
   logic [19:0]         w_rem_sh;
   logic [19:0]         w_trial;
   logic                w_ge;
   logic [15:0]         w_std;

   assign w_sq   = 32'(i_sample) * 32'(i_sample);
   assign w_mean = 16'(r_sum >> LOG2_N);
   assign w_ex2  = 32'(r_sumsq >> LOG2_N);
   assign w_mm   = 32'(w_mean) * 32'(w_mean);
   assign w_var  = (w_ex2 >= w_mm) ? (w_ex2 - w_mm) : 32'd0;

   // Restoring sqrt step: bring down two radicand bits, try 4*root+1.
   assign w_rem_sh = {r_rem[17:0], r_rad[31:30]};
   assign w_trial  = {2'b00, r_root, 2'b01};
   assign w_ge     = (w_rem_sh >= w_trial);

`ifdef CALIB_STD_CLAMP_EN
   assign w_std = (r_root == 16'd0) ? 16'd1 : r_root;
`else
   assign w_std = r_root;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
         r_sum   <= '0;
         r_sumsq <= '0;
         r_cnt   <= '0;
         r_it    <= '0;
         r_mean  <= '0;
         r_rad   <= '0;
         r_rem   <= '0;
         r_root  <= '0;
         o_mean  <= '0;
         o_std   <= STD_RST;
         o_valid <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_sum   <= '0;
                  r_sumsq <= '0;
                  r_cnt   <= '0;
                  o_busy  <= 1'b1;
                  r_state <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (i_sample_valid) begin
                  r_sum   <= r_sum + {{LOG2_N{1'b0}}, i_sample};
                  r_sumsq <= r_sumsq + {{LOG2_N{1'b0}}, w_sq};
                  r_cnt   <= r_cnt + 1'b1;
                  if (r_cnt == '1)
                     r_state <= S_VAR;
               end
            end
            S_VAR: begin
               r_mean  <= w_mean;
               r_rad   <= w_var;
               r_rem   <= '0;
               r_root  <= '0;
               r_it    <= '0;
               r_state <= S_SQRT;
            end
            S_SQRT: begin
               if (r_it == 5'd16) begin
                  r_state <= S_DONE;
               end else begin
                  r_rem  <= w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
                  r_root <= {r_root[14:0], w_ge};
                  r_rad  <= {r_rad[29:0], 2'b00};
                  r_it   <= r_it + 5'd1;
               end
            end
            S_DONE: begin
               o_mean  <= r_mean;
               o_std   <= w_std;
               o_valid <= 1'b1;
               o_done  <= 1'b1;
               o_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calib_stats.sv
// Directed scoreboard bench for calib_stats (LOG2_N = 6).
// Honours CALIB_STD_CLAMP_EN for expected std and reset values.
module tb_calib_stats;

   logic        clk = 1'b0;
   logic        i_reset_n;
   logic        i_start;
   logic        i_sample_valid;
   logic [15:0] i_sample;
   logic [15:0] o_mean;
   logic [15:0] o_std;
   logic        o_valid;
   logic        o_busy;
   logic        o_done;

   always #5 clk = ~clk;

   calib_stats #(.LOG2_N(6)) dut (
      .i_clk          (clk),
      .i_reset_n      (i_reset_n),
      .i_start        (i_start),
      .i_sample_valid (i_sample_valid),
      .i_sample       (i_sample),
      .o_mean         (o_mean),
      .o_std          (o_std),
      .o_valid        (o_valid),
      .o_busy         (o_busy),
      .o_done         (o_done)
   );

   typedef struct {
      logic [15:0] m;
      logic [15:0] s;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] smp[64];
   logic [15:0] prev_mean;
   logic [15:0] prev_std;
   logic        prev_valid;
   int          errors = 0;
   int          checks = 0;

`ifdef CALIB_STD_CLAMP_EN
   localparam logic [15:0] STD_RST = 16'd1;
`else
   localparam logic [15:0] STD_RST = 16'd0;
`endif

   function automatic logic [15:0] clampf(input logic [15:0] r);
`ifdef CALIB_STD_CLAMP_EN
      return (r == 16'd0) ? 16'd1 : r;
`else
      return r;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic feed(input bit bub, input bit poke);
      i_start        = 1'b1;
      i_sample_valid = 1'b1;
      i_sample       = 16'd5000;
      @(negedge clk);
      i_start        = 1'b0;
      i_sample_valid = 1'b0;
      chk("busy_rise", o_busy, 1);
      for (int i = 0; i < 64; i++) begin
         if (bub) begin
            i_sample_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         i_sample_valid = 1'b1;
         i_sample       = smp[i];
         i_start        = (poke && i == 20);
         @(negedge clk);
         i_start        = 1'b0;
         i_sample_valid = 1'b0;
      end
   endtask

   task automatic run_cal(input bit bub, input bit poke,
                          input logic [15:0] em, input logic [15:0] es);
      exp_t e;
      int   n;
      int   extra;
      bit   done;
      e.m = em;
      e.s = es;
      sb.push_back(e);
      feed(bub, poke);
      n = 0;
      done = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         i_start = (poke && n == 6);
         if (n == 10) begin
            chk("hold_mean", o_mean, prev_mean);
            chk("hold_std", o_std, prev_std);
            chk("hold_valid", o_valid, prev_valid);
         end
         if (o_done) done = 1;
      end
      i_start = 1'b0;
      chk("latency", n, 19);
      if (done && sb.size() > 0) begin
         e = sb.pop_front();
         chk("mean", o_mean, e.m);
         chk("std", o_std, e.s);
         chk("valid", o_valid, 1);
         chk("busy_fall", o_busy, 0);
         prev_mean  = e.m;
         prev_std   = e.s;
         prev_valid = 1'b1;
      end else begin
         chk("done_seen", 0, 1);
      end
      extra = 0;
      repeat (25) begin
         @(negedge clk);
         if (o_done) extra++;
      end
      chk("single_done", extra, 0);
      chk("idle_after", o_busy, 0);
   endtask

   initial begin
      int n;
      int extra;
      i_reset_n      = 1'b0;
      i_start        = 1'b0;
      i_sample_valid = 1'b0;
      i_sample       = 16'd0;
      prev_mean      = 16'd0;
      prev_std       = STD_RST;
      prev_valid     = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mean", o_mean, 0);
      chk("rst_std", o_std, STD_RST);
      chk("rst_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      i_reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 64; i++) smp[i] = 16'd1000;
      run_cal(0, 0, 16'd1000, clampf(16'd0));

      for (int i = 0; i < 64; i++) smp[i] = (i % 2) ? 16'd300 : 16'd100;
      run_cal(0, 0, 16'd200, 16'd100);

      for (int i = 0; i < 64; i++) smp[i] = 16'(i);
      run_cal(0, 0, 16'd31, 16'd19);

      for (int i = 0; i < 64; i++) smp[i] = 16'hFFFF;
      run_cal(0, 0, 16'd65535, clampf(16'd0));

      for (int i = 0; i < 64; i++) smp[i] = (i % 2) ? 16'hFFFF : 16'd0;
      run_cal(0, 0, 16'd32767, 16'd32767);

      for (int i = 0; i < 64; i++) smp[i] = 16'(i);
      run_cal(1, 1, 16'd31, 16'd19);

      for (int i = 0; i < 64; i++) smp[i] = (i % 2) ? 16'd300 : 16'd100;
      run_cal(0, 0, 16'd200, 16'd100);

      for (int i = 0; i < 64; i++) smp[i] = 16'(i);
      feed(0, 0);
      n = 0;
      while (n < 8) begin
         @(negedge clk);
         n++;
      end
      i_reset_n = 1'b0;
      @(negedge clk);
      chk("mrst_valid", o_valid, 0);
      chk("mrst_mean", o_mean, 0);
      chk("mrst_std", o_std, STD_RST);
      chk("mrst_busy", o_busy, 0);
      chk("mrst_done", o_done, 0);
      i_reset_n = 1'b1;
      extra = 0;
      repeat (25) begin
         @(negedge clk);
         if (o_done) extra++;
      end
      chk("mrst_no_done", extra, 0);
      prev_mean  = 16'd0;
      prev_std   = STD_RST;
      prev_valid = 1'b0;

      run_cal(0, 0, 16'd31, 16'd19);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/calib_stats.md
# calib_stats

Per-channel calibration statistics engine for the flex-sensor front end. It accumulates a fixed window of raw integer sensor samples and computes the integer mean and standard deviation. These feed the `i_mean` / `i_std` inputs of the normalization stage directly downstream. Results are held in registers until the next calibration completes, so the normalizer always sees a stable, consistent pair.

## Interface
Parameters:
- `LOG2_N`, default 6: window length N = 2^LOG2_N samples; legal range 1..10.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_reset_n`  in  1  reset, synchronous, active-low.
- `i_start`  in  1  request a new calibration; honoured only in IDLE.
- `i_sample_valid`  in  1  `i_sample` carries a new sample this cycle.
- `i_sample`  in  16  raw sensor sample, unsigned.
- `o_mean`  out  16  window mean, unsigned integer.
- `o_std`  out  16  window standard deviation, unsigned integer.
- `o_valid`  out  1  `o_mean` / `o_std` hold a completed result.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse when new results appear.

## Operation
- States: IDLE, ACCUM, VAR, SQRT, DONE.
- **IDLE → ACCUM:** on `i_start`. Clears `sum`, `sumsq` and the sample counter. A sample presented in the same cycle as `i_start` is not counted.
- **ACCUM:** each cycle with `i_sample_valid`:
  - `sum += i_sample`, width 16+LOG2_N.
  - `sumsq += i_sample*i_sample`, width 32+LOG2_N.
  - Counter increments.
  - Gaps in `i_sample_valid` are allowed.
  - On acceptance of sample N → VAR.
- **VAR (1 cycle):**
  - `mean = sum >> LOG2_N` (truncate).
  - `ex2 = sumsq >> LOG2_N` (truncate, 32 bits).
  - `var = ex2 - mean*mean`, 32-bit.
  - If the subtraction underflows, `var = 0`.
  - → SQRT.
- **SQRT (16 cycles):** restoring bit-serial integer square root, one result bit per cycle, MSB first. Result is `root = floor(sqrt(var))`, 16 bits. → DONE.
- **DONE (1 cycle):**
  - Registers `o_mean = mean` and `o_std = root`, both updated in the same edge.
  - Sets `o_valid = 1`.
  - Pulses `o_done`.
  - → IDLE.
- **Command handling:**
  - `i_start` outside IDLE is ignored (no restart, no queuing).
  - `i_sample_valid` outside ACCUM is ignored.
- **Output stability:** previous `o_mean` / `o_std` / `o_valid` are held unchanged throughout a new calibration.
- **Reset, at any state including mid-ACCUM or mid-SQRT:**
  - State returns to IDLE and accumulators clear.
  - `o_mean = 0`, `o_valid = 0`, `o_busy = 0`, `o_done = 0`.
  - `o_std` takes its reset value, defined under Configuration.

## Timing
- Accumulation throughput: one sample per cycle.
- Let edge E0 be the edge accepting sample N:
  - E1 leaves VAR.
  - E2..E17 perform the sqrt iterations.
  - E18 enters DONE.
  - E19 registers the outputs.
- `o_done` is high for exactly one cycle, coinciding with the first cycle new `o_mean` / `o_std` are visible, i.e. after E19.
- `o_busy` rises the cycle after the `i_start` edge. It falls in the same cycle `o_done` is high.
- Earliest next `i_start` is accepted in the `o_done` cycle, since the FSM is already in IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `CALIB_STD_CLAMP_EN` defined:
  - The stored `o_std` is `max(root, 1)`.
  - `o_std` reset value is 1.
  - This guarantees the downstream divider never sees zero.
- Not defined:
  - `o_std = root` exactly, which may be 0.
  - `o_std` reset value is 0.

## Test plan
- **Constant window:** 64 samples of 1000 (LOG2_N=6) → `o_mean` = 1000; `o_std` = 1 with clamp, 0 without; `o_done` exactly 19 edges after the last sample.
- **Alternating window:** 100/300 ×32 pairs → `o_mean` = 200, `o_std` = 100.
- **Ramp:** 0..63, one per cycle → `o_mean` = 31, var = 1333 − 961 = 372, `o_std` = 19.
- **Full-scale extremes:**
  - 64 × 65535 → `o_mean` = 65535, var = 0, `o_std` = 1 with clamp.
  - Alternating 0/65535 → `o_mean` = 32767, var = 1073741823, `o_std` = 32767.
- **Bubbles and ignored start:** ramp repeated with random `i_sample_valid` gaps → identical results; `i_start` pulsed during ACCUM and during SQRT → ignored, single `o_done`.
- **Reset mid-operation:**
  - Complete one calibration (mean 200).
  - Start a second and assert `i_reset_n = 0` during SQRT → next cycle `o_valid` = 0, `o_mean` = 0, `o_std` at its reset value, `o_busy` = 0, no `o_done`.
  - A new calibration then completes normally.
